// File: rtl/int_seq_if.sv
// -----------------------------------------------------------------------------
// int_seq_if : bus bundle between the interrupt sequencer and its neighbours.
//   IRQ_SRC  [7:0]  raw asynchronous peripheral interrupt lines
//   IRQ_REQ         request to the core (registered in the sequencer)
//   IRQ_VEC  [23:0] vector address, stable while IRQ_REQ=1
//   IRQ_CODE [2:0]  source number being requested
//   IRQ_ACK         one-cycle acknowledge from the core
//   WB_*            8-bit Wishbone slave (zero wait state, WB_ACKo tied 1)
// The master modport is the system side (core + bus master + sources).
// The slave modport is the sequencer itself.
// -----------------------------------------------------------------------------
interface int_seq_if;
  logic [7:0]  IRQ_SRC;
  logic        IRQ_REQ;
  logic [23:0] IRQ_VEC;
  logic [2:0]  IRQ_CODE;
  logic        IRQ_ACK;
  logic [2:0]  WB_ADRi;
  logic [7:0]  WB_DATi;
  logic [7:0]  WB_DATo;
  logic        WB_WEi;
  logic        WB_CYCi;
  logic        WB_STBi;
  logic        WB_ACKo;

  modport master (
    output IRQ_SRC, IRQ_ACK, WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
    input  IRQ_REQ, IRQ_VEC, IRQ_CODE, WB_DATo, WB_ACKo
  );

  modport slave (
    input  IRQ_SRC, IRQ_ACK, WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
    output IRQ_REQ, IRQ_VEC, IRQ_CODE, WB_DATo, WB_ACKo
  );
endinterface

// File: rtl/int_seq.sv
// -----------------------------------------------------------------------------
// int_seq : interrupt sequencer for the LS1u core.
// Tracks pending and in-service sources, nests by priority (highest index
// wins), and presents one vector at a time to the core with a req/ack
// handshake. Configuration and end-of-interrupt go through an 8-bit Wishbone
// slave.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : int_seq_if.slave (IRQ_SRC/REQ/VEC/CODE/ACK and WB_* signals)
// Register map (WB_ADRi):
//   0 CTRL  {EN, 5'b0, VSIZ[1:0]}
//   1..3    VBASE[7:0] / [15:8] / [23:16]
//   4 MASK  1 = source enabled
//   5 TRIG  1 = edge, 0 = level
//   6 PEND  read pending, write-1-clears edge-pending bits
//   7 ISR   read in-service, any write = EOI (clears highest set ISR bit)
// -----------------------------------------------------------------------------
module int_seq #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  int_seq_if.slave bus
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_q, state_d;
  logic              irqReq_q, irqReq_d;
  logic [23:0]       irqVec_q, irqVec_d;
  logic [2:0]        irqCode_q, irqCode_d;

  logic              en_q;
  logic [1:0]        vsiz_q;
  logic [23:0]       vbase_q;
  logic [NSRC-1:0]   mask_q;
  logic [NSRC-1:0]   trig_q;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [NSRC-1:0]   isr_q, isr_d;

  logic [NSRC-1:0]   sync_q [SYNC_STAGES];
  logic [NSRC-1:0]   hist_q;

  logic [NSRC-1:0]   syncOut;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   eligible;
  logic [2:0]        winner;
  logic [2:0]        isrTop;
  logic              accept;
  logic              wbWrite;
  logic [NSRC-1:0]   w1cMask;
  logic [NSRC-1:0]   eoiClr;
  logic [NSRC-1:0]   ackSet;
  logic [2:0]        shAmt;
  logic [7:0]        rdData;

  // Index of the highest set bit; 0 when nothing is set (callers qualify).
  function automatic logic [2:0] highestIdx(input logic [NSRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Source synchronizer chain plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= bus.IRQ_SRC;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign syncOut  = sync_q[SYNC_STAGES-1];
  assign rise     = syncOut & ~hist_q;
  assign wbWrite  = bus.WB_CYCi & bus.WB_STBi & bus.WB_WEi;
  assign eligible = pend_q & mask_q;
  assign winner   = highestIdx(eligible);
  assign isrTop   = highestIdx(isr_q);

  // A new request must outrank everything already in service.
  assign accept = en_q && (|eligible) && ((isr_q == '0) || (winner > isrTop));

  assign w1cMask = (wbWrite && bus.WB_ADRi == 3'd6) ? bus.WB_DATi : '0;

  // EOI acts on the ISR as it stood before any same-cycle ACK.
  assign eoiClr = (wbWrite && bus.WB_ADRi == 3'd7 && (|isr_q))
                  ? (NSRC'(1) << isrTop) : '0;

  assign shAmt = 3'd2 + {1'b0, vsiz_q};

  // Configuration registers; PEND and ISR are handled with the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      vsiz_q  <= 2'd0;
      vbase_q <= '0;
      mask_q  <= '0;
      trig_q  <= '0;
    end else if (wbWrite) begin
      case (bus.WB_ADRi)
        3'd0: begin
          en_q   <= bus.WB_DATi[7];
          vsiz_q <= bus.WB_DATi[1:0];
        end
        3'd1: vbase_q[7:0]   <= bus.WB_DATi;
        3'd2: vbase_q[15:8]  <= bus.WB_DATi;
        3'd3: vbase_q[23:16] <= bus.WB_DATi;
        3'd4: mask_q         <= bus.WB_DATi;
        3'd5: trig_q         <= bus.WB_DATi;
        default: ;
      endcase
    end
  end

  // Request FSM. Withdrawal only happens when no ACK arrives that cycle.
  always_comb begin
    state_d   = state_q;
    irqReq_d  = irqReq_q;
    irqVec_d  = irqVec_q;
    irqCode_d = irqCode_q;
    ackSet    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          irqCode_d = winner;
          irqVec_d  = vbase_q + (24'(winner) << shAmt);
          irqReq_d  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus.IRQ_ACK) begin
          irqReq_d = 1'b0;
          ackSet   = NSRC'(1) << irqCode_q;
          state_d  = IDLE;
        end else if (!(pend_q[irqCode_q] && mask_q[irqCode_q] && en_q)) begin
          irqReq_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge bits: clears first, so a same-cycle rising edge wins.
  // Level bits simply follow the synchronized line.
  always_comb begin
    pend_d = (trig_q & ((pend_q & ~(w1cMask | ackSet)) | rise))
           | (~trig_q & syncOut);
    isr_d  = (isr_q & ~eoiClr) | ackSet;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irqReq_q  <= 1'b0;
      irqVec_q  <= '0;
      irqCode_q <= '0;
      pend_q    <= '0;
      isr_q     <= '0;
    end else begin
      state_q   <= state_d;
      irqReq_q  <= irqReq_d;
      irqVec_q  <= irqVec_d;
      irqCode_q <= irqCode_d;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
    end
  end

  always_comb begin
    rdData = '0;
    case (bus.WB_ADRi)
      3'd0: rdData = {en_q, 5'b0, vsiz_q};
      3'd1: rdData = vbase_q[7:0];
      3'd2: rdData = vbase_q[15:8];
      3'd3: rdData = vbase_q[23:16];
      3'd4: rdData = mask_q;
      3'd5: rdData = trig_q;
      3'd6: rdData = pend_q;
      3'd7: rdData = isr_q;
      default: rdData = '0;
    endcase
  end

  assign bus.WB_DATo  = rdData;
  assign bus.WB_ACKo  = 1'b1;
  assign bus.IRQ_REQ  = irqReq_q;
  assign bus.IRQ_VEC  = irqVec_q;
  assign bus.IRQ_CODE = irqCode_q;

endmodule
